// File: rtl/icevga_pkg.sv
// Shared constants and types for the icevga host read-back path.
// VRAM geometry, bus direction encoding and the responder FSM states.
package icevga_pkg;

   localparam int BUS_AW      = 11;
   localparam int BANK_W      = 2;
   localparam int VRAM_AW     = BUS_AW + BANK_W;
   localparam int SYNC_STAGES = 2;

   localparam logic DIR_HOST_TO_FPGA = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRIVE,
      ST_RELEASE
   } rb_state_e;

endpackage

// File: rtl/host_readback_if.sv
// Host bus strobes, VRAM read port and data-bus control for read-back.
// slave = responder side, master = host/arbiter/EBR side.
interface host_readback_if #(
   parameter int BUS_AW = 11,
   parameter int BANK_W = 2
);

   logic [BUS_AW-1:0]        hostBusAddr;
   logic                     nHostRMEM;
   logic                     nHostVRAMEn;
   logic                     nHostBankRegEn;
   logic [BANK_W-1:0]        bankReg;
   logic                     vramRdReq;
   logic                     vramRdGnt;
   logic [BUS_AW+BANK_W-1:0] vramRdAddr;
   logic [7:0]               vramRdData;
   logic [7:0]               hostRdData;
   logic                     hostRdOE;
   logic                     hostBusDir;

   modport slave (
      input  hostBusAddr,
      input  nHostRMEM,
      input  nHostVRAMEn,
      input  nHostBankRegEn,
      input  bankReg,
      output vramRdReq,
      input  vramRdGnt,
      output vramRdAddr,
      input  vramRdData,
      output hostRdData,
      output hostRdOE,
      output hostBusDir
   );

   modport master (
      output hostBusAddr,
      output nHostRMEM,
      output nHostVRAMEn,
      output nHostBankRegEn,
      output bankReg,
      input  vramRdReq,
      output vramRdGnt,
      input  vramRdAddr,
      output vramRdData,
      input  hostRdData,
      input  hostRdOE,
      input  hostBusDir
   );

endinterface

// File: rtl/input_sync.sv
// N-stage synchronizer for active-low host strobes.
// Resets to 1 so a strobe reads as inactive until it is really seen.
module input_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic nrst,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] sync_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < N; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/host_readback.sv
// Host memory-read responder: borrows the VRAM read port or returns
// the bank register, and sequences OE/direction without contention.
module host_readback
   import icevga_pkg::*;
#(
   parameter int BUS_AW      = icevga_pkg::BUS_AW,
   parameter int BANK_W      = icevga_pkg::BANK_W,
   parameter int SYNC_STAGES = icevga_pkg::SYNC_STAGES
) (
   input  logic            clk,
   input  logic            nrst,
   host_readback_if.slave  bus
);

   localparam int AW = BUS_AW + BANK_W;

   logic rmem_s;
   logic vram_s;
   logic bank_s;

   input_sync #(.N(SYNC_STAGES)) u_sync_rmem (
      .clk  (clk),
      .nrst (nrst),
      .d_i  (bus.nHostRMEM),
      .q_o  (rmem_s)
   );

   input_sync #(.N(SYNC_STAGES)) u_sync_vram (
      .clk  (clk),
      .nrst (nrst),
      .d_i  (bus.nHostVRAMEn),
      .q_o  (vram_s)
   );

   input_sync #(.N(SYNC_STAGES)) u_sync_bank (
      .clk  (clk),
      .nrst (nrst),
      .d_i  (bus.nHostBankRegEn),
      .q_o  (bank_s)
   );

   rb_state_e       state_q, state_d;
   logic            rmem_prev_q;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      data_q, data_d;
   logic            rmem_fall;
   logic            req;
   logic            oe;
   logic            dir;

   assign rmem_fall = rmem_prev_q & ~rmem_s;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_IDLE;
         rmem_prev_q <= 1'b1;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         rmem_prev_q <= rmem_s;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   // OE/dir decode straight from state so reset frees the bus at once
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      req     = 1'b0;
      oe      = 1'b0;
      dir     = DIR_HOST_TO_FPGA;
      unique case (state_q)
         ST_IDLE: begin
            if (rmem_fall && !vram_s) begin
               addr_d  = {bus.bankReg, bus.hostBusAddr};
               state_d = ST_REQ;
            end else if (rmem_fall && !bank_s) begin
               data_d  = 8'(bus.bankReg);
               state_d = ST_DRIVE;
            end
         end
         ST_REQ: begin
            if (rmem_s) begin
               state_d = ST_IDLE;
            end else begin
               req = 1'b1;
               if (bus.vramRdGnt) state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (rmem_s) begin
               state_d = ST_IDLE;
            end else begin
               data_d  = bus.vramRdData;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            oe  = 1'b1;
            dir = ~DIR_HOST_TO_FPGA;
            if (rmem_s) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            dir     = ~DIR_HOST_TO_FPGA;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.vramRdReq  = req;
   assign bus.vramRdAddr = addr_q;
   assign bus.hostRdData = data_q;
   assign bus.hostRdOE   = oe;
   assign bus.hostBusDir = dir;

endmodule

// File: tb/tb_host_readback.sv
// Directed bench for host_readback: bank, VRAM, stalled grant, abort,
// mid-read reset and unselected strobes.
module tb_host_readback;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic [7:0] ebr_byte = 8'h00;
   int n_cmp = 0;
   int n_bad = 0;
   int oe_cycles = 0;
   bit watch = 1'b0;

   always #20 clk = ~clk;

   host_readback_if bus ();

   host_readback dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // EBR model: data valid only the cycle after req&gnt
   always @(posedge clk)
      bus.vramRdData <= (bus.vramRdReq && bus.vramRdGnt) ? ebr_byte : 8'h5c;

   always @(negedge clk) begin
      if (nrst) begin
         check("oe_dir", 32'(bus.hostRdOE & bus.hostBusDir), 32'd0);
         if (watch && bus.hostRdOE) oe_cycles++;
      end
   end

   task automatic bus_idle(int n);
      bus.nHostRMEM      = 1'b1;
      bus.nHostVRAMEn    = 1'b1;
      bus.nHostBankRegEn = 1'b1;
      bus.vramRdGnt      = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_read(
      string tag, bit use_vram, logic [10:0] addr, logic [1:0] bk,
      int rise_k, int gnt_low, int ncyc,
      int oe_s, int oe_e, int req_s, int req_e,
      logic [12:0] exp_addr, logic [7:0] exp_data
   );
      bit e_oe;
      bit e_dir;
      bit e_req;
      bus.hostBusAddr    = addr;
      bus.bankReg        = bk;
      bus.nHostVRAMEn    = !use_vram;
      bus.nHostBankRegEn = use_vram;
      bus.nHostRMEM      = 1'b0;
      bus.vramRdGnt      = (0 >= 3 + gnt_low);
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk);
         @(negedge clk);
         e_oe  = (k >= oe_s) && (k <= oe_e);
         e_dir = !((k >= oe_s) && (k <= oe_e + 1));
         e_req = (k >= req_s) && (k <= req_e);
         check({tag, "_oe"}, 32'(bus.hostRdOE), 32'(e_oe));
         check({tag, "_dir"}, 32'(bus.hostBusDir), 32'(e_dir));
         check({tag, "_req"}, 32'(bus.vramRdReq), 32'(e_req));
         if (k == oe_s)
            check({tag, "_data"}, 32'(bus.hostRdData), 32'(exp_data));
         if (use_vram && k == req_s)
            check({tag, "_addr"}, 32'(bus.vramRdAddr), 32'(exp_addr));
         if (k == rise_k) begin
            bus.nHostRMEM      = 1'b1;
            bus.nHostVRAMEn    = 1'b1;
            bus.nHostBankRegEn = 1'b1;
         end
         bus.vramRdGnt = (k >= 3 + gnt_low);
      end
      bus_idle(3);
   endtask

   initial begin
      bus.hostBusAddr    = '0;
      bus.bankReg        = '0;
      bus.nHostRMEM      = 1'b1;
      bus.nHostVRAMEn    = 1'b1;
      bus.nHostBankRegEn = 1'b1;
      bus.vramRdGnt      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", 32'(bus.vramRdReq), 32'd0);
      check("rst_addr", 32'(bus.vramRdAddr), 32'd0);
      check("rst_data", 32'(bus.hostRdData), 32'd0);
      check("rst_oe", 32'(bus.hostRdOE), 32'd0);
      check("rst_dir", 32'(bus.hostBusDir), 32'd1);
      nrst = 1'b1;
      bus_idle(3);

      do_read("bank", 1'b0, 11'h000, 2'b10, 10, 0, 16,
              3, 12, -1, -2, 13'h0, 8'h02);
      ebr_byte = 8'hA5;
      do_read("vram", 1'b1, 11'h123, 2'b01, 10, 0, 16,
              5, 12, 3, 3, 13'h0923, 8'hA5);
      ebr_byte = 8'h3C;
      do_read("stall", 1'b1, 11'h456, 2'b10, 14, 7, 20,
              12, 16, 3, 10, 13'h1456, 8'h3C);
      ebr_byte = 8'hEE;
      do_read("abort", 1'b1, 11'h0AA, 2'b00, 4, 20, 10,
              -1, -2, 3, 5, 13'h00AA, 8'h00);
      check("abort_hold", 32'(bus.hostRdData), 32'h3C);

      bus.bankReg        = 2'b11;
      bus.nHostBankRegEn = 1'b0;
      bus.nHostRMEM      = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("pre_rst_oe", 32'(bus.hostRdOE), 32'd1);
      #1 nrst = 1'b0;
      #1;
      check("mid_rst_oe", 32'(bus.hostRdOE), 32'd0);
      check("mid_rst_dir", 32'(bus.hostBusDir), 32'd1);
      bus.nHostRMEM      = 1'b1;
      bus.nHostBankRegEn = 1'b1;
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      bus_idle(4);
      ebr_byte = 8'h81;
      do_read("post_rst", 1'b1, 11'h7FF, 2'b11, 10, 0, 16,
              5, 12, 3, 3, 13'h1FFF, 8'h81);

      watch = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.hostBusAddr = 11'($urandom);
         bus.nHostRMEM   = 1'b0;
         repeat ($urandom_range(1, 6)) @(posedge clk);
         #1 bus.nHostRMEM = 1'b1;
         repeat ($urandom_range(3, 6)) @(posedge clk);
         #1;
      end
      repeat (4) @(posedge clk);
      #1 watch = 1'b0;
      check("nosel_oe", 32'(oe_cycles), 32'd0);
      check("nosel_req", 32'(bus.vramRdReq), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
